// File: rtl/vedic_pp_sequencer_8x8.sv
// Sequential 8x8 unsigned Urdhva-Tiryagbhyam multiplier front end: one shared 4x4 core,
// cross terms summed through an external 16-bit adder that is driven and sampled each ADD cycle.
module vedic_pp_sequencer_8x8 #(
  parameter int A_W       = 8,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a_in,
  input  logic [A_W-1:0] b_in,
  output logic [15:0]    add_a,
  output logic [15:0]    add_b,
  output logic           add_cin,
  input  logic [15:0]    add_sum,
  input  logic           add_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    product,
  output logic           busy,
  output logic           err
);

  if (A_W != 8) begin : g_width_check
    $error("vedic_pp_sequencer_8x8 supports only A_W == 8");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD1 = 3'd2,
    S_ADD2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Vertical-and-crosswise 4x4: column sums of bit products, then weighted accumulation.
  function automatic logic [7:0] vedic_4x4(input logic [3:0] x, input logic [3:0] y);
    logic [2:0] col [0:6];
    logic [7:0] sum;
    for (int c = 0; c < 7; c++) col[c] = 3'd0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        col[i+j] = col[i+j] + {2'b00, x[i] & y[j]};
    sum = 8'd0;
    for (int c = 0; c < 7; c++) sum = sum + ({5'd0, col[c]} << c);
    return sum;
  endfunction

  state_t      state_r, state_n_s;
  logic [1:0]  k_r;
  logic [7:0]  a_r, b_r;
  logic [7:0]  pp0_r, pp1_r, pp2_r, pp3_r;
  logic [15:0] acc_r, product_r;
  logic        zero_r, err_r;
  logic [3:0]  core_x_s, core_y_s;
  logic [7:0]  core_pp_s;

  // Operand nibble selection for the shared core, one sub-product per MUL cycle.
  always_comb begin
    core_x_s = a_r[3:0];
    core_y_s = b_r[3:0];
    case (k_r)
      2'd0: begin core_x_s = a_r[3:0]; core_y_s = b_r[3:0]; end
      2'd1: begin core_x_s = a_r[7:4]; core_y_s = b_r[7:4]; end
      2'd2: begin core_x_s = a_r[7:4]; core_y_s = b_r[3:0]; end
      2'd3: begin core_x_s = a_r[3:0]; core_y_s = b_r[7:4]; end
      default: begin core_x_s = 4'd0; core_y_s = 4'd0; end
    endcase
  end

  assign core_pp_s = vedic_4x4(core_x_s, core_y_s);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_n_s;
  end

  // Next-state logic; a zero operand spends its single MUL cycle jumping straight to DONE.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE: if (in_valid) state_n_s = S_MUL; else state_n_s = S_IDLE;
      S_MUL: begin
        if (zero_r)            state_n_s = S_DONE;
        else if (k_r == 2'd3)  state_n_s = S_ADD1;
        else                   state_n_s = S_MUL;
      end
      S_ADD1: state_n_s = S_ADD2;
      S_ADD2: state_n_s = S_DONE;
      S_DONE: if (out_ready) state_n_s = S_IDLE; else state_n_s = S_DONE;
      default: state_n_s = S_IDLE;
    endcase
  end

  // Datapath registers: operand latch, sub-products, accumulator, result and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r       <= 2'd0;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      pp0_r     <= 8'd0;
      pp1_r     <= 8'd0;
      pp2_r     <= 8'd0;
      pp3_r     <= 8'd0;
      acc_r     <= 16'd0;
      product_r <= 16'd0;
      zero_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r    <= a_in;
            b_r    <= b_in;
            k_r    <= 2'd0;
            zero_r <= SKIP_ZERO && ((a_in == 8'd0) || (b_in == 8'd0));
          end
        end
        S_MUL: begin
          if (zero_r) begin
            product_r <= 16'd0;
          end else begin
            case (k_r)
              2'd0: pp0_r <= core_pp_s;
              2'd1: pp1_r <= core_pp_s;
              2'd2: pp2_r <= core_pp_s;
              2'd3: pp3_r <= core_pp_s;
              default: pp0_r <= pp0_r;
            endcase
            k_r <= k_r + 2'd1;
            if (k_r == 2'd3) acc_r <= {pp1_r, pp0_r};
          end
        end
        S_ADD1: begin
          acc_r <= add_sum;
          if (add_cout) err_r <= 1'b1;
        end
        S_ADD2: begin
          product_r <= add_sum;
          if (add_cout) err_r <= 1'b1;
        end
        default: begin
          k_r <= k_r;
        end
      endcase
    end
  end

  // Adder operand steering: quiet except during the two cross-term additions.
  always_comb begin
    add_a = 16'd0;
    add_b = 16'd0;
    case (state_r)
      S_ADD1: begin add_a = acc_r; add_b = {4'b0000, pp2_r, 4'b0000}; end
      S_ADD2: begin add_a = acc_r; add_b = {4'b0000, pp3_r, 4'b0000}; end
      default: begin add_a = 16'd0; add_b = 16'd0; end
    endcase
  end

  assign add_cin   = 1'b0;
  assign in_ready  = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign out_valid = (state_r == S_DONE);
  assign product   = product_r;
  assign err       = err_r;

endmodule

// File: tb/tb_vedic_pp_sequencer_8x8.sv
// Directed bench for vedic_pp_sequencer_8x8 with a behavioural model of the downstream adder.
module tb_vedic_pp_sequencer_8x8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_in = 8'd0;
  logic [7:0]  b_in = 8'd0;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        busy, err;
  logic        force_cout = 1'b0;
  logic [16:0] add_full;

  int err_cnt = 0;
  int chk_cnt = 0;

  vedic_pp_sequencer_8x8 #(.A_W(8), .SKIP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy), .err(err)
  );

  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign add_sum  = add_full[15:0];
  assign add_cout = add_full[16] | force_cout;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat, output logic [15:0] add_seen);
    a_in = a; b_in = b; in_valid = 1'b1;
    lat = 0; add_seen = 16'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = ~a; b_in = ~b;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      add_seen = add_seen | add_a | add_b;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) check_val("op_timeout", {31'd0, out_valid}, 32'd1);
    p = product;
  endtask

  task automatic drain(input bit stall);
    for (int n = 0; n < 64; n++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == 63) out_ready = 1'b1;
      @(posedge clk); #1;
      if (out_ready) break;
    end
    out_ready = 1'b1;
  endtask

  logic [15:0] p, seen, expp;
  int lat;
  logic [7:0] vals [16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h11, 8'h7F, 8'h80,
                            8'h81, 8'hAA, 8'h55, 8'hFE, 8'hFF, 8'h3C, 8'hC3, 8'h99};

  initial begin
    #12;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_product", {16'd0, product}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_add_a", {16'd0, add_a}, 32'd0);
    check_val("rst_add_b", {16'd0, add_b}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Max operands: 6-cycle latency
    run_op(8'hFF, 8'hFF, p, lat, seen);
    check_val("ff_latency", lat, 32'd6);
    check_val("ff_product", {16'd0, p}, 32'h0000FE01);
    check_val("ff_err", {31'd0, err}, 32'd0);
    drain(1'b0);

    // 0x12*0x34 with adder operands observed, inputs wiggled while busy
    a_in = 8'h12; b_in = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    a_in = 8'h77; b_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check_val("add1_a", {16'd0, add_a}, 32'h0308);
    check_val("add1_b", {16'd0, add_b}, 32'h0040);
    check_val("add1_cin", {31'd0, add_cin}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("add2_a", {16'd0, add_a}, 32'h0348);
    check_val("add2_b", {16'd0, add_b}, 32'h0060);
    @(posedge clk); #1;
    check_val("x12_valid", {31'd0, out_valid}, 32'd1);
    check_val("x12_product", {16'd0, product}, 32'h03A8);
    drain(1'b0);

    // Zero bypass
    run_op(8'h00, 8'h5A, p, lat, seen);
    check_val("zero_latency", lat, 32'd1);
    check_val("zero_product", {16'd0, p}, 32'd0);
    check_val("zero_add_quiet", {16'd0, seen}, 32'd0);
    drain(1'b0);

    // Back-pressure in DONE
    out_ready = 1'b0;
    run_op(8'h0A, 8'h0B, p, lat, seen);
    check_val("bp_latency", lat, 32'd6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("bp_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_product", {16'd0, product}, 32'h006E);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check_val("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check_val("bp_product_hold", {16'd0, product}, 32'h006E);

    // Reset while in MUL with k==2
    a_in = 8'h5B; b_in = 8'hC7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_product", {16'd0, product}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 16'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | {15'd0, out_valid};
    end
    check_val("abort_no_valid", {16'd0, seen}, 32'd0);
    run_op(8'h0F, 8'h11, p, lat, seen);
    check_val("post_rst_product", {16'd0, p}, 32'h00FF);
    drain(1'b0);

    // Operand sweep with random consumer stalls
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(vals[i], vals[j], p, lat, seen);
        expp = {8'd0, vals[i]} * {8'd0, vals[j]};
        check_val("sweep_product", {16'd0, p}, {16'd0, expp});
        check_val("sweep_latency", lat, ((vals[i] == 8'd0) || (vals[j] == 8'd0)) ? 32'd1 : 32'd6);
        drain(1'b1);
      end
    end
    check_val("sweep_err", {31'd0, err}, 32'd0);

    // Forced carry-out during ADD1 sets sticky err
    a_in = 8'h21; b_in = 8'h43; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    force_cout = 1'b1;
    @(posedge clk); #1;
    force_cout = 1'b0;
    check_val("cout_err_set", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    check_val("cout_valid", {31'd0, out_valid}, 32'd1);
    check_val("cout_product", {16'd0, product}, 32'h08A3);
    drain(1'b0);
    run_op(8'h03, 8'h05, p, lat, seen);
    check_val("err_sticky_prod", {16'd0, p}, 32'h000F);
    check_val("err_sticky", {31'd0, err}, 32'd1);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
